// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin bus arbiter slice.
package arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;

  typedef logic [15:0] stat_cnt_t;

  localparam stat_cnt_t STAT_MAX = 16'hFFFF;

  // Index width that stays at least 1 bit when only one master exists
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Request/grant bundle between bus masters and the arbiter.
// Statistics signals are present only when BUS_ARB_STATS_EN is defined.
interface bus_rr_arbiter_if
  import arb_pkg::*;
#(
  parameter int unsigned NMASTERS = 2
);
  localparam int unsigned OW = idx_w(NMASTERS);

  logic [NMASTERS-1:0] m_req;
  logic [NMASTERS-1:0] m_gnt;
  logic [OW-1:0]       owner;
  logic                owner_vld;
  logic                preempt;
`ifdef BUS_ARB_STATS_EN
  logic [OW-1:0]       stat_sel;
  stat_cnt_t           stat_grants;
  stat_cnt_t           stat_preempts;

  modport master (output m_req, stat_sel,
                  input  m_gnt, owner, owner_vld, preempt, stat_grants, stat_preempts);
  modport slave  (input  m_req, stat_sel,
                  output m_gnt, owner, owner_vld, preempt, stat_grants, stat_preempts);
`else
  modport master (output m_req,
                  input  m_gnt, owner, owner_vld, preempt);
  modport slave  (input  m_req,
                  output m_gnt, owner, owner_vld, preempt);
`endif

endinterface

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set req bit after index 'last', wrapping.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned W = idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] pick,
  output logic         any
);

  int unsigned idx;
  logic [W-1:0] k;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = 0;
    k    = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(last) + i) % N;
      k   = W'(idx);
      if (!any && req[k]) begin
        pick = k;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with hold limit and one dead cycle between owners.
// Optional grant/preemption counters when BUS_ARB_STATS_EN is defined.
module bus_rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned NMASTERS = 2,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset,
  bus_rr_arbiter_if.slave  bus
);

  localparam int unsigned OW = idx_w(NMASTERS);
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);
  localparam logic [OW-1:0] LAST_RST = OW'(NMASTERS - 1);

  arb_state_t          state_q, state_n;
  logic [NMASTERS-1:0] gnt_q, gnt_n;
  logic [OW-1:0]       owner_q, owner_n;
  logic [OW-1:0]       last_q, last_n;
  logic [HW-1:0]       hold_q, hold_n;
  logic                vld_q, vld_n;
  logic                preempt_q, preempt_n;
  logic                grant_fire;
  logic [OW-1:0]       pick;
  logic                any_req;
  logic                others;

  rr_pick #(.N(NMASTERS)) u_pick (
    .req  (bus.m_req),
    .last (last_q),
    .pick (pick),
    .any  (any_req)
  );

  assign others = |(bus.m_req & ~gnt_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      last_q    <= LAST_RST;
      hold_q    <= '0;
      vld_q     <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      gnt_q     <= gnt_n;
      owner_q   <= owner_n;
      last_q    <= last_n;
      hold_q    <= hold_n;
      vld_q     <= vld_n;
      preempt_q <= preempt_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    gnt_n      = gnt_q;
    owner_n    = owner_q;
    last_n     = last_q;
    hold_n     = hold_q;
    vld_n      = vld_q;
    preempt_n  = 1'b0;
    grant_fire = 1'b0;
    case (state_q)
      // RELEASE is the dead cycle; it arbitrates exactly like IDLE on its edge
      IDLE, RELEASE: begin
        gnt_n   = '0;
        vld_n   = 1'b0;
        state_n = IDLE;
        if (any_req) begin
          gnt_n[pick] = 1'b1;
          owner_n     = pick;
          last_n      = pick;
          hold_n      = HOLD_ONE;
          vld_n       = 1'b1;
          state_n     = GRANT;
          grant_fire  = 1'b1;
        end
      end
      GRANT: begin
        if (!bus.m_req[owner_q]) begin
          gnt_n   = '0;
          vld_n   = 1'b0;
          state_n = RELEASE;
        end else if (others && hold_q == HOLD_MAX) begin
          gnt_n     = '0;
          vld_n     = 1'b0;
          preempt_n = 1'b1;
          state_n   = RELEASE;
        end else if (hold_q != HOLD_MAX) begin
          hold_n = hold_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.m_gnt     = gnt_q;
  assign bus.owner     = owner_q;
  assign bus.owner_vld = vld_q;
  assign bus.preempt   = preempt_q;

`ifdef BUS_ARB_STATS_EN
  stat_cnt_t grant_cnt [NMASTERS];
  stat_cnt_t preempt_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NMASTERS; i++) grant_cnt[i] <= '0;
      preempt_cnt <= '0;
    end else begin
      if (grant_fire && grant_cnt[pick] != STAT_MAX)
        grant_cnt[pick] <= grant_cnt[pick] + 1'b1;
      if (preempt_n && preempt_cnt != STAT_MAX)
        preempt_cnt <= preempt_cnt + 1'b1;
    end
  end

  assign bus.stat_grants   = (32'(bus.stat_sel) < NMASTERS) ? grant_cnt[bus.stat_sel] : '0;
  assign bus.stat_preempts = preempt_cnt;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: three instances cover 2/4 masters and hold limits.
module tb_bus_rr_arbiter;

  logic clk = 1'b0;
  logic rst2, rst2h, rst4;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bus_rr_arbiter_if #(.NMASTERS(2)) b2  ();
  bus_rr_arbiter_if #(.NMASTERS(2)) b2h ();
  bus_rr_arbiter_if #(.NMASTERS(4)) b4  ();

  bus_rr_arbiter #(.NMASTERS(2), .MAX_HOLD(4))  u2  (.clk(clk), .reset(rst2),  .bus(b2));
  bus_rr_arbiter #(.NMASTERS(2), .MAX_HOLD(16)) u2h (.clk(clk), .reset(rst2h), .bus(b2h));
  bus_rr_arbiter #(.NMASTERS(4), .MAX_HOLD(16)) u4  (.clk(clk), .reset(rst4),  .bus(b4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected u2 grant/preempt pattern with MAX_HOLD=4 and both masters requesting
  logic [1:0] pat_gnt [12] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10,
                               2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01};
  logic       pat_pre [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    rst2 = 1'b0; rst2h = 1'b0; rst4 = 1'b0;
    b2.m_req = '0; b2h.m_req = '0; b4.m_req = '0;
`ifdef BUS_ARB_STATS_EN
    b2.stat_sel = '0; b2h.stat_sel = '0; b4.stat_sel = '0;
`endif
    #12;
    chk("rst_gnt",     32'(b2.m_gnt), 32'h0);
    chk("rst_vld",     32'(b2.owner_vld), 32'h0);
    chk("rst_owner",   32'(b2.owner), 32'h0);
    chk("rst_preempt", 32'(b2.preempt), 32'h0);
    #11;
    rst2 = 1'b1; rst2h = 1'b1; rst4 = 1'b1;

    // Idle with no requests
    tick(5);
    chk("idle_gnt", 32'(b2.m_gnt), 32'h0);
    chk("idle_vld", 32'(b2.owner_vld), 32'h0);

    // Simultaneous requests: last=1 after reset so master 0 wins
    b2.m_req = 2'b11;
    tick(1);
    chk("sim_gnt",   32'(b2.m_gnt), 32'h1);
    chk("sim_owner", 32'(b2.owner), 32'h0);
    chk("sim_vld",   32'(b2.owner_vld), 32'h1);
    b2.m_req = 2'b10;
    tick(1);
    chk("dead_gnt",  32'(b2.m_gnt), 32'h0);
    chk("dead_pre",  32'(b2.preempt), 32'h0);
    tick(1);
    chk("hand_gnt",   32'(b2.m_gnt), 32'h2);
    chk("hand_owner", 32'(b2.owner), 32'h1);
    b2.m_req = 2'b00;
    tick(2);
    chk("back_idle", 32'(b2.m_gnt), 32'h0);

    // Hold limit rotation: last=1, so 0 first
    b2.m_req = 2'b11;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk($sformatf("rot_gnt%0d", i), 32'(b2.m_gnt), 32'(pat_gnt[i]));
      chk($sformatf("rot_pre%0d", i), 32'(b2.preempt), 32'(pat_pre[i]));
    end
    b2.m_req = 2'b00;
    tick(2);

    // Async reset mid-grant, then re-arbitrate from last=NMASTERS-1
    b2.m_req = 2'b11;
    tick(1);
    chk("pre_rst_gnt", 32'(b2.m_gnt), 32'h2);
    #2 rst2 = 1'b0;
    #1;
    chk("async_gnt", 32'(b2.m_gnt), 32'h0);
    chk("async_vld", 32'(b2.owner_vld), 32'h0);
    chk("async_pre", 32'(b2.preempt), 32'h0);
    #2 rst2 = 1'b1;
    tick(1);
    chk("post_rst_gnt", 32'(b2.m_gnt), 32'h1);
    b2.m_req = 2'b00;
    tick(2);

    // Lone requester holds indefinitely without preemption
    b2h.m_req = 2'b10;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      chk($sformatf("lone_gnt%0d", i), 32'(b2h.m_gnt), 32'h2);
      chk($sformatf("lone_pre%0d", i), 32'(b2h.preempt), 32'h0);
    end
    b2h.m_req = 2'b00;

    // Four masters: master 2 holds, then 1011 yields 3, 0, 1
    b4.m_req = 4'b0100;
    tick(2);
    chk("m4_g2", 32'(b4.m_gnt), 32'h4);
    chk("m4_o2", 32'(b4.owner), 32'h2);
    b4.m_req = 4'b1011;
    tick(1);
    chk("m4_dead1", 32'(b4.m_gnt), 32'h0);
    tick(1);
    chk("m4_g3", 32'(b4.m_gnt), 32'h8);
    chk("m4_o3", 32'(b4.owner), 32'h3);
    b4.m_req = 4'b0011;
    tick(1);
    chk("m4_dead2", 32'(b4.m_gnt), 32'h0);
    tick(1);
    chk("m4_g0", 32'(b4.m_gnt), 32'h1);
    b4.m_req = 4'b0010;
    tick(1);
    chk("m4_dead3", 32'(b4.m_gnt), 32'h0);
    tick(1);
    chk("m4_g1", 32'(b4.m_gnt), 32'h2);
    chk("m4_o1", 32'(b4.owner), 32'h1);

`ifdef BUS_ARB_STATS_EN
    // Fresh counters: 3 grants to master 1, 2 preemptions
    #2 rst2 = 1'b0;
    #2 rst2 = 1'b1;
    b2.m_req = 2'b11;
    tick(11);
    b2.m_req = 2'b10;
    tick(2);
    b2.m_req = 2'b00;
    tick(2);
    b2.m_req = 2'b10;
    tick(1);
    chk("st_gnt", 32'(b2.m_gnt), 32'h2);
    b2.stat_sel = 1'b1;
    #1;
    chk("st_grants1", 32'(b2.stat_grants), 32'd3);
    chk("st_preempts", 32'(b2.stat_preempts), 32'd2);
    b2.stat_sel = 1'b0;
    #1;
    chk("st_grants0", 32'(b2.stat_grants), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Grants must never overlap
  always @(negedge clk) begin
    assert ($onehot0(b2.m_gnt) && $onehot0(b2h.m_gnt) && $onehot0(b4.m_gnt))
      else begin
        n_err++;
        $display("FAIL onehot: got %b/%b/%b expected at most one bit", b2.m_gnt, b2h.m_gnt, b4.m_gnt);
      end
  end

endmodule
